// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator for a word-addressed, byte-masked data memory.
// Optional MISALIGNED_SPLIT_EN splits word-crossing accesses into two word accesses instead of faulting.
module load_store_unit #(
    parameter int DM_ADDR_WIDTH = 10,
    parameter int XLEN          = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mem_req,
    input  logic                     mem_write,
    input  logic [2:0]               funct3,
    input  logic [XLEN-1:0]          addr,
    input  logic [XLEN-1:0]          store_data,
    output logic                     req_ready,
    output logic                     done,
    output logic                     fault,
    output logic [XLEN-1:0]          load_data,
    output logic                     dm_read_enable,
    output logic                     dm_write_enable,
    output logic [DM_ADDR_WIDTH-1:0] dm_address,
    output logic [XLEN-1:0]          dm_write_data,
    output logic [3:0]               dm_write_mask,
    input  logic [XLEN-1:0]          dm_read_data
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, WAIT} state_t;
    state_t state, state_nxt;
    logic [1:0] off, off_q;
    logic [2:0] f3_q;
    logic [3:0] wmask, hi_mask, wm_nxt;
    logic [7:0] m8;
    logic [2*XLEN-1:0] d64, r64;
    logic [XLEN-1:0] hi_data, word_a, r, ext, wd_nxt, ld_nxt;
    logic [DM_ADDR_WIDTH-1:0] adr_nxt;
    logic legal, misal_bad, bad, split, split_q, store_q;
    logic re_nxt, we_nxt, done_nxt, fault_nxt;
    logic unused_bits;
    assign off       = addr[1:0];
    assign wmask     = funct3[1] ? 4'b1111 : funct3[0] ? 4'b0011 : 4'b0001;
    assign m8        = {4'b0, wmask} << off;
    assign d64       = {{XLEN{1'b0}}, store_data} << {off, 3'b0};
    assign split     = |m8[7:4];
    assign legal     = (funct3 inside {3'b000, 3'b001, 3'b010}) || (!mem_write && (funct3 inside {3'b100, 3'b101}));
`ifdef MISALIGNED_SPLIT_EN
    assign misal_bad = 1'b0;
`else
    assign misal_bad = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
`endif
    assign bad       = !legal || misal_bad;
    assign req_ready = state == IDLE;
    // The last word read is on dm_read_data in WAIT; word A was captured in ACC2 when split.
    assign r64 = {split_q ? dm_read_data : {XLEN{1'b0}}, split_q ? word_a : dm_read_data} >> {off_q, 3'b0};
    assign r   = r64[XLEN-1:0];
    assign ext = f3_q == 3'b000 ? {{(XLEN-8){r[7]}}, r[7:0]} :
                 f3_q == 3'b001 ? {{(XLEN-16){r[15]}}, r[15:0]} :
                 f3_q == 3'b100 ? {{(XLEN-8){1'b0}}, r[7:0]} :
                 f3_q == 3'b101 ? {{(XLEN-16){1'b0}}, r[15:0]} : r;
    assign unused_bits = ^{addr[XLEN-1:DM_ADDR_WIDTH+2], r64[2*XLEN-1:XLEN]};

    always_comb begin
        state_nxt = state;
        re_nxt    = 1'b0;
        we_nxt    = 1'b0;
        adr_nxt   = '0;
        wd_nxt    = '0;
        wm_nxt    = '0;
        done_nxt  = 1'b0;
        fault_nxt = 1'b0;
        ld_nxt    = '0;
        case (state)
            IDLE: if (mem_req) begin
                if (bad) begin
                    done_nxt  = 1'b1;
                    fault_nxt = 1'b1;
                end else begin
                    state_nxt = ACC1;
                    re_nxt    = !mem_write;
                    we_nxt    = mem_write;
                    adr_nxt   = addr[DM_ADDR_WIDTH+1:2];
                    wm_nxt    = mem_write ? m8[3:0] : 4'b0;
                    wd_nxt    = mem_write ? d64[XLEN-1:0] : {XLEN{1'b0}};
                end
            end
            ACC1: if (split_q) begin
                state_nxt = ACC2;
                re_nxt    = !store_q;
                we_nxt    = store_q;
                adr_nxt   = dm_address + 1'b1;
                wm_nxt    = hi_mask;
                wd_nxt    = hi_data;
            end else begin
                state_nxt = store_q ? IDLE : WAIT;
                done_nxt  = store_q;
            end
            ACC2: begin
                state_nxt = store_q ? IDLE : WAIT;
                done_nxt  = store_q;
            end
            default: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                ld_nxt    = ext;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            dm_read_enable  <= 1'b0;
            dm_write_enable <= 1'b0;
            dm_address      <= '0;
            dm_write_data   <= '0;
            dm_write_mask   <= '0;
            done            <= 1'b0;
            fault           <= 1'b0;
            load_data       <= '0;
            store_q         <= 1'b0;
            split_q         <= 1'b0;
            f3_q            <= '0;
            off_q           <= '0;
            hi_mask         <= '0;
            hi_data         <= '0;
            word_a          <= '0;
        end else begin
            state           <= state_nxt;
            dm_read_enable  <= re_nxt;
            dm_write_enable <= we_nxt;
            dm_address      <= adr_nxt;
            dm_write_data   <= wd_nxt;
            dm_write_mask   <= wm_nxt;
            done            <= done_nxt;
            fault           <= fault_nxt;
            load_data       <= ld_nxt;
            if (state == IDLE && mem_req) begin
                store_q <= mem_write;
                split_q <= split;
                f3_q    <= funct3;
                off_q   <= off;
                hi_mask <= mem_write ? m8[7:4] : 4'b0;
                hi_data <= mem_write ? d64[2*XLEN-1:XLEN] : {XLEN{1'b0}};
            end
            if (state == ACC2) word_a <= dm_read_data;
        end
    end
endmodule
